// File: rtl/tick_ctrl_if.sv
// rtl/tick_ctrl_if.sv - button/period/run/tick bundle between the control stage and its host
// Optional step input present only when TICK_STEP_EN is defined.
interface tick_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             btn;
  logic [WIDTH-1:0] period_n;
  logic             run;
  logic             tick;
`ifdef TICK_STEP_EN
  logic             step;

  modport master (output btn, output period_n, output step, input run, input tick);
  modport slave  (input btn, input period_n, input step, output run, output tick);
`else
  modport master (output btn, output period_n, input run, input tick);
  modport slave  (input btn, input period_n, output run, output tick);
`endif
endinterface

// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - debounced run/stop toggle and programmable tick generator for the BCD counter
// Optional single-step input enabled by defining TICK_STEP_EN.
module tick_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  tick_ctrl_if.slave  bus
);

  localparam int SW = $clog2(DEB_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEB_CYCLES - 1);

`ifdef TICK_STEP_EN
  localparam int NPATH = 2;
  logic [NPATH-1:0] raw;
  assign raw = {bus.step, bus.btn};
`else
  localparam int NPATH = 1;
  logic [NPATH-1:0] raw;
  assign raw = bus.btn;
`endif

  logic [NPATH-1:0] sync1, sync2, deb, accept, rise;
  logic [SW-1:0]    stab [NPATH];

  // Each input path: two-flop synchroniser, then a level is accepted once it
  // has differed from deb for DEB_CYCLES consecutive samples.
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < NPATH; i++) begin
      accept[i] = (sync2[i] != deb[i]) && (stab[i] == STAB_LAST);
      rise[i]   = accept[i] && sync2[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NPATH; i++) stab[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NPATH; i++) begin
        if (sync2[i] == deb[i]) begin
          stab[i] <= '0;
        end else if (accept[i]) begin
          deb[i]  <= sync2[i];
          stab[i] <= '0;
        end else begin
          stab[i] <= stab[i] + 1'b1;
        end
      end
    end
  end

  logic press;
  logic step_rise;
  assign press = rise[0];
`ifdef TICK_STEP_EN
  assign step_rise = rise[1];
`else
  assign step_rise = 1'b0;
`endif

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= STOP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (press) state_nxt = (state == STOP) ? RUN : STOP;
  end

  always_comb begin
    bus.run = 1'b0;
    if (state == RUN) bus.run = 1'b1;
  end

  logic [WIDTH-1:0] cnt;
  logic             tick_q;
  assign bus.tick = tick_q;

  // A press always wins over a pending tick; entering RUN reloads so no
  // partial period survives a stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (press) begin
      tick_q <= 1'b0;
      if (state == STOP) cnt <= bus.period_n;
    end else if (state == RUN) begin
      if (cnt == '0) begin
        tick_q <= 1'b1;
        cnt    <= bus.period_n;
      end else begin
        tick_q <= 1'b0;
        cnt    <= cnt - 1'b1;
      end
    end else begin
      tick_q <= step_rise;
    end
  end

endmodule

// File: doc/tick_ctrl.md
Name: tick_ctrl

Overview:
Upstream control stage for the BCD up-counter. Converts a raw push-button into a debounced run/stop toggle and generates the single-cycle enable pulse (`tick`) that drives the counter's `en` input. While running, `tick` fires at a programmable period; while stopped, `tick` stays low and the counter holds.

Parameters:
- WIDTH, 16: width of the period register and the prescaler counter.
- DEB_CYCLES, 4: number of consecutive stable synchronised samples needed to accept a button level change. Must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- btn  in  1  raw asynchronous push-button, active-high, may bounce.
- period_n  in  WIDTH  tick period minus one, in clk cycles. Sampled only at prescaler reload.
- run  out  1  1 = running, 0 = stopped.
- tick  out  1  registered single-cycle enable pulse to the counter.

Behaviour:
- Reset (rst high at an edge), all registers cleared:
  - sync flops = 0, debounced level `deb` = 0, stability counter = 0.
  - run = 0, prescaler count = 0, tick = 0.
  - rst has priority over every other event, including mid-debounce and mid-period.
- Synchroniser: btn passes through two flops (sync1 → sync2). Only sync2 is used downstream.
- Debounce, evaluated each edge:
  - If sync2 == deb: stab <= 0.
  - Else if stab == DEB_CYCLES-1: deb <= sync2, stab <= 0.
  - Else: stab <= stab+1.
  - Any glitch back to the deb value restarts the count.
  - The stab counter is $clog2(DEB_CYCLES+1) bits wide.
- Press detect: a press is the edge at which deb goes 0→1. Release (1→0) has no effect on run.
- Run FSM, states STOP (run=0) and RUN (run=1):
  - STOP→RUN on a press. At the same edge: prescaler <= period_n, tick <= 0.
  - RUN→STOP on a press. At the same edge: tick <= 0, prescaler holds its value (unused on exit).
- Latency: btn rising before edge 1, held stable, gives deb and run updating at edge DEB_CYCLES+2 (edge 6 at default).
- Prescaler, in RUN with no press:
  - If cnt == 0: tick <= 1, cnt <= period_n.
  - Else: tick <= 0, cnt <= cnt-1.
- Prescaler, in STOP: tick <= 0, cnt holds.
- Timing consequences:
  - First tick is high in the cycle following edge E+period_n+1, where E is the entry edge.
  - Thereafter tick is high exactly 1 cycle in every period_n+1 cycles.
- Boundaries:
  - period_n = 0: tick is high every cycle in RUN, starting the cycle after edge E+1.
  - period_n = all-ones: period is 2^WIDTH cycles, with no overflow (the count only decrements).
  - period_n changed mid-period: takes effect at the next reload only.
  - Re-entering RUN always reloads, so no partial period carries over from before STOP.
  - A press on the same edge the prescaler would tick: the FSM transition wins and tick <= 0.

Optional Feature:
Macro TICK_STEP_EN.
- Defined:
  - Adds input `step` (1 bit), which is synchronised and debounced by an identical second path (same DEB_CYCLES).
  - In STOP, a debounced step 0→1 edge sets tick <= 1 for exactly one cycle; run stays 0 and the prescaler is untouched.
  - In RUN, step is ignored.
  - If a btn press and a step edge land on the same edge, the btn press wins and no step tick occurs.
- Undefined: no `step` port, no extra logic, behaviour exactly as above.

Test Plan:
1. Reset and debounce acceptance: rst for 2 cycles, then btn=1 held, DEB_CYCLES=4 → run=0, tick=0 after reset; run becomes 1 at edge 6 after btn rose.
2. Bounce rejection: btn pulses 1 for 2 cycles, 0 for 1, then 1 held → no premature toggle; run=1 only 6 edges after the final rise.
3. Period check: period_n=3, enter RUN at edge E → tick high after edges E+4, E+8, E+12; never two consecutive highs; the counter downstream advances 0→1→2→3.
4. Continuous and stop: period_n=0 → tick high every cycle from E+1. Second press → run=0 and tick=0 from the toggle edge, and tick stays 0 for 50 cycles.
5. Reset mid-operation: in RUN with period_n=10, assert rst at cnt=5 → next cycle run=0, tick=0; a fresh press restarts with the first tick 11 cycles after entry.
6. (TICK_STEP_EN) In STOP, debounced step pulse → exactly one tick cycle and run=0. In RUN, step pulses cause no extra ticks (period remains period_n+1).
